// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared RGB565 type, fixed 16-colour palette and attribute layout for the text renderer
package text_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Character buffer word: {attr[7:0], char[7:0]}
    localparam int CHAR_LSB    = 0;
    localparam int CHAR_W      = 8;
    localparam int ATTR_LSB    = 8;
    localparam int ATTR_W      = 8;

    // Colour index fields inside the attribute byte
    localparam int ATTR_FG_LSB = 0;
    localparam int ATTR_BG_LSB = 4;
    localparam int COLOR_IDX_W = 4;

    // CGA-style palette reduced to RGB565: index 0 black, index 15 white
    localparam logic [15:0] PALETTE [16] = '{
        16'h0000, 16'h0015, 16'h0540, 16'h0555,
        16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
        16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
        16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
    };

    function automatic rgb565_t palette_lookup(input logic [COLOR_IDX_W-1:0] idx);
        return rgb565_t'(PALETTE[idx]);
    endfunction

endpackage

// File: rtl/text_blink_ctrl.sv
// rtl/text_blink_ctrl.sv - vsync rising-edge detector, frame counter and cursor blink phase
module text_blink_ctrl #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vsync,
    output logic o_blink_phase
);

    logic       r_vsync_d;
    logic [7:0] r_frame_cnt;
    logic       r_blink_phase;
    logic       w_vsync_rise;

    assign w_vsync_rise  = i_vsync & ~r_vsync_d;
    assign o_blink_phase = r_blink_phase;

    // Count frames on each vsync rising edge; wrap and flip the blink phase every BLINK_FRAMES frames
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync_d     <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_blink_phase <= 1'b1;
        end else begin
            r_vsync_d <= i_vsync;
            if (w_vsync_rise) begin
                if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= 8'd0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/text_attr_renderer.sv
// rtl/text_attr_renderer.sv - three-stage attributed text renderer; cursor/blink built only with TEXT_CURSOR_EN
module text_attr_renderer
    import text_pkg::*;
#(
    parameter int  FONT_W       = 8,
    parameter int  FONT_H       = 16,
    parameter int  COLS         = 64,
    parameter int  ROWS         = 32,
    parameter int  BLINK_FRAMES = 30,
    localparam int ADDR_W       = ($clog2(COLS * ROWS) < 1) ? 1 : $clog2(COLS * ROWS),
    localparam int FH_LOG2      = $clog2(FONT_H),
    localparam int FW_LOG2      = $clog2(FONT_W),
    localparam int FADDR_W      = CHAR_W + FH_LOG2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [9:0]         i_x,
    input  logic [9:0]         i_y,
    input  logic               i_hde,
    input  logic               i_vde,
    input  logic               i_hsync,
    input  logic               i_vsync,
    output logic [ADDR_W-1:0]  o_vram_addr,
    input  logic [15:0]        i_vram_data,
    output logic [FADDR_W-1:0] o_font_addr,
    input  logic [FONT_W-1:0]  i_font_row,
    input  logic [6:0]         i_cursor_col,
    input  logic [5:0]         i_cursor_row,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_den,
    output logic [4:0]         o_r,
    output logic [5:0]         o_g,
    output logic [4:0]         o_b
);

    if (FONT_W < 4 || FONT_W > 16 || (FONT_W & (FONT_W - 1)) != 0) begin : g_bad_font_w
        $error("text_attr_renderer: FONT_W must be a power of two in 4..16");
    end
    if (FONT_H < 8 || FONT_H > 32 || (FONT_H & (FONT_H - 1)) != 0) begin : g_bad_font_h
        $error("text_attr_renderer: FONT_H must be a power of two in 8..32");
    end
    if (COLS < 1 || COLS > 128) begin : g_bad_cols
        $error("text_attr_renderer: COLS must be in 1..128");
    end
    if (ROWS < 1 || ROWS > 64) begin : g_bad_rows
        $error("text_attr_renderer: ROWS must be in 1..64");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
        $error("text_attr_renderer: BLINK_FRAMES must be in 1..255");
    end

    // Stage 0 decode of the incoming pixel position
    logic [9:0]         w_col;
    logic [9:0]         w_row;
    logic [FW_LOG2-1:0] w_pix_col;
    logic [FH_LOG2-1:0] w_glyph_row;
    logic               w_cell_valid;
    logic [ADDR_W-1:0]  w_lin_addr;
    logic               w_cursor_hit;

    assign w_col        = i_x >> FW_LOG2;
    assign w_row        = i_y >> FH_LOG2;
    assign w_pix_col    = i_x[FW_LOG2-1:0];
    assign w_glyph_row  = i_y[FH_LOG2-1:0];
    assign w_cell_valid = (w_col < 10'(COLS)) && (w_row < 10'(ROWS));
    // Address wraps modulo the buffer size for off-screen cells; their data is discarded later
    assign w_lin_addr   = ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col);

`ifdef TEXT_CURSOR_EN
    logic w_blink_phase;

    text_blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_vsync       (i_vsync),
        .o_blink_phase (w_blink_phase)
    );

    // Underline the bottom two glyph rows of the cursor cell while the blink phase is on
    assign w_cursor_hit = w_blink_phase
                        && (8'(i_cursor_col) < 8'(COLS))
                        && (7'(i_cursor_row) < 7'(ROWS))
                        && (w_col == 10'(i_cursor_col))
                        && (w_row == 10'(i_cursor_row))
                        && (w_glyph_row >= FH_LOG2'(FONT_H - 2));
`else
    logic w_unused_cursor;

    assign w_unused_cursor = ^{i_cursor_col, i_cursor_row};
    assign w_cursor_hit    = 1'b0;
`endif

    // Stage 0 registers
    logic               r0_hsync;
    logic               r0_vsync;
    logic               r0_den;
    logic               r0_valid;
    logic               r0_cursor;
    logic [FW_LOG2-1:0] r0_pix_col;
    logic [FH_LOG2-1:0] r0_glyph_row;
    logic [ADDR_W-1:0]  r_vram_addr;

    // Stage 1 registers
    logic               r1_hsync;
    logic               r1_vsync;
    logic               r1_den;
    logic               r1_valid;
    logic               r1_cursor;
    logic [FW_LOG2-1:0] r1_pix_col;
    logic [ATTR_W-1:0]  r1_attr;
    logic [FADDR_W-1:0] r_font_addr;

    // Stage 2 (output) registers
    logic               r2_hsync;
    logic               r2_vsync;
    logic               r2_den;
    rgb565_t            r_rgb;

    // Stage 0: cell address, in-cell coordinates, cursor match and timing flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r0_hsync     <= 1'b0;
            r0_vsync     <= 1'b0;
            r0_den       <= 1'b0;
            r0_valid     <= 1'b0;
            r0_cursor    <= 1'b0;
            r0_pix_col   <= '0;
            r0_glyph_row <= '0;
            r_vram_addr  <= '0;
        end else begin
            r0_hsync     <= i_hsync;
            r0_vsync     <= i_vsync;
            r0_den       <= i_hde & i_vde;
            r0_valid     <= w_cell_valid;
            r0_cursor    <= w_cursor_hit;
            r0_pix_col   <= w_pix_col;
            r0_glyph_row <= w_glyph_row;
            r_vram_addr  <= w_lin_addr;
        end
    end

    // Stage 1: turn the character code into a font address and hold the attribute byte
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r1_hsync    <= 1'b0;
            r1_vsync    <= 1'b0;
            r1_den      <= 1'b0;
            r1_valid    <= 1'b0;
            r1_cursor   <= 1'b0;
            r1_pix_col  <= '0;
            r1_attr     <= '0;
            r_font_addr <= '0;
        end else begin
            r1_hsync    <= r0_hsync;
            r1_vsync    <= r0_vsync;
            r1_den      <= r0_den;
            r1_valid    <= r0_valid;
            r1_cursor   <= r0_cursor;
            r1_pix_col  <= r0_pix_col;
            r1_attr     <= i_vram_data[ATTR_LSB +: ATTR_W];
            r_font_addr <= {i_vram_data[CHAR_LSB +: CHAR_W], r0_glyph_row};
        end
    end

    // Stage 2 pixel selection: glyph bit (MSB leftmost) or cursor picks fg, otherwise bg
    logic [FW_LOG2-1:0]     w_bit_idx;
    logic                   w_pixel;
    logic [COLOR_IDX_W-1:0] w_color_idx;
    rgb565_t                w_color;

    assign w_bit_idx   = FW_LOG2'(FONT_W - 1) - r1_pix_col;
    assign w_pixel     = i_font_row[w_bit_idx] | r1_cursor;
    assign w_color_idx = w_pixel ? r1_attr[ATTR_FG_LSB +: COLOR_IDX_W]
                                 : r1_attr[ATTR_BG_LSB +: COLOR_IDX_W];
    assign w_color     = (r1_den && r1_valid) ? palette_lookup(w_color_idx) : '0;

    // Stage 2: load the aligned output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r2_hsync <= 1'b0;
            r2_vsync <= 1'b0;
            r2_den   <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r2_hsync <= r1_hsync;
            r2_vsync <= r1_vsync;
            r2_den   <= r1_den;
            r_rgb    <= w_color;
        end
    end

    assign o_vram_addr = r_vram_addr;
    assign o_font_addr = r_font_addr;
    assign o_hsync     = r2_hsync;
    assign o_vsync     = r2_vsync;
    assign o_den       = r2_den;
    assign o_r         = r_rgb.r;
    assign o_g         = r_rgb.g;
    assign o_b         = r_rgb.b;

endmodule

// File: tb/tb_text_attr_renderer.sv
// tb/tb_text_attr_renderer.sv - directed and randomized self-checking bench for text_attr_renderer
module tb_text_attr_renderer;

    localparam int FW    = 8;
    localparam int FH    = 16;
    localparam int NC    = 60;
    localparam int NR    = 30;
    localparam int BF    = 2;
    localparam int NCELL = NC * NR;
    localparam int MAXC  = 4096;

    // 24-bit CGA colours; the RGB565 palette is their top bits
    localparam logic [23:0] CGA [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

    typedef struct packed {
        logic       rst;
        logic [9:0] x;
        logic [9:0] y;
        logic       hde;
        logic       vde;
        logic       hs;
        logic       vs;
        logic [6:0] ccol;
        logic [5:0] crow;
    } in_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [9:0]  i_x = '0;
    logic [9:0]  i_y = '0;
    logic        i_hde = 1'b0;
    logic        i_vde = 1'b0;
    logic        i_hsync = 1'b0;
    logic        i_vsync = 1'b0;
    logic [10:0] o_vram_addr;
    logic [15:0] i_vram_data;
    logic [11:0] o_font_addr;
    logic [7:0]  i_font_row;
    logic [6:0]  i_cursor_col = 7'd3;
    logic [5:0]  i_cursor_row = 6'd2;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_den;
    logic [4:0]  o_r;
    logic [5:0]  o_g;
    logic [4:0]  o_b;

    logic [15:0] vram [0:NCELL-1];
    logic [7:0]  font [0:4095];

    in_t         hist     [0:MAXC-1];
    logic        ph_log   [0:MAXC-1];
    logic [18:0] obs_log  [0:MAXC-1];
    logic [10:0] addr_log [0:MAXC-1];
    logic [11:0] faddr_log[0:MAXC-1];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    logic m_ph = 1'b1;
    logic m_prev = 1'b0;
    logic [6:0] cur_col = 7'd3;
    logic [5:0] cur_row = 6'd2;
    in_t  rv;
    int   cpos15 [5];
    int   cpos13 [5];

    always #5 i_clk = ~i_clk;

    assign i_vram_data = (o_vram_addr < 11'(NCELL)) ? vram[o_vram_addr] : 16'hA5A5;
    assign i_font_row  = font[o_font_addr];

    text_attr_renderer #(
        .FONT_W       (FW),
        .FONT_H       (FH),
        .COLS         (NC),
        .ROWS         (NR),
        .BLINK_FRAMES (BF)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_hde        (i_hde),
        .i_vde        (i_vde),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .o_vram_addr  (o_vram_addr),
        .i_vram_data  (i_vram_data),
        .o_font_addr  (o_font_addr),
        .i_font_row   (i_font_row),
        .i_cursor_col (i_cursor_col),
        .i_cursor_row (i_cursor_row),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync),
        .o_den        (o_den),
        .o_r          (o_r),
        .o_g          (o_g),
        .o_b          (o_b)
    );

    function automatic logic [15:0] pal(input logic [3:0] idx);
        logic [23:0] c;
        c = CGA[idx];
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

    // Expected {hsync, vsync, den, rgb565} for one input sample
    function automatic logic [18:0] model(input in_t v, input logic ph);
        int col, row, gr, pc, addr;
        logic [15:0] w;
        logic [7:0]  fr;
        logic        pix;
        logic        den;
        col = int'(v.x) / FW;
        row = int'(v.y) / FH;
        gr  = int'(v.y) % FH;
        pc  = int'(v.x) % FW;
        den = v.hde & v.vde;
        if (!den || col >= NC || row >= NR) return {v.hs, v.vs, den, 16'h0000};
        addr = row * NC + col;
        w    = vram[addr];
        fr   = font[int'(w[7:0]) * FH + gr];
        pix  = fr[FW - 1 - pc];
`ifdef TEXT_CURSOR_EN
        if (ph && col == int'(v.ccol) && row == int'(v.crow) && gr >= FH - 2) pix = 1'b1;
`else
        if (ph === 1'bx) pix = 1'b0;
`endif
        return {v.hs, v.vs, 1'b1, pal(pix ? w[11:8] : w[15:12])};
    endfunction

    function automatic in_t mk(input logic rst, input int x, input int y,
                               input logic hde, input logic vde, input logic hs, input logic vs);
        in_t v;
        v.rst  = rst;
        v.x    = 10'(x);
        v.y    = 10'(y);
        v.hde  = hde;
        v.vde  = vde;
        v.hs   = hs;
        v.vs   = vs;
        v.ccol = cur_col;
        v.crow = cur_row;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs, compare with the sample three cycles back, then drive the next input
    task automatic step(input in_t v);
        logic [18:0] exp;
        @(negedge i_clk);
        obs_log[cyc]   = {o_hsync, o_vsync, o_den, o_r, o_g, o_b};
        addr_log[cyc]  = o_vram_addr;
        faddr_log[cyc] = o_font_addr;
        if (cyc >= 3) begin
            if (hist[cyc-1].rst || hist[cyc-2].rst || hist[cyc-3].rst) exp = '0;
            else exp = model(hist[cyc-3], ph_log[cyc-3]);
            check($sformatf("pix@%0d", cyc), 32'(obs_log[cyc]), 32'(exp));
        end
        i_rst        = v.rst;
        i_x          = v.x;
        i_y          = v.y;
        i_hde        = v.hde;
        i_vde        = v.vde;
        i_hsync      = v.hs;
        i_vsync      = v.vs;
        i_cursor_col = v.ccol;
        i_cursor_row = v.crow;
        hist[cyc]    = v;
        ph_log[cyc]  = m_ph;
        if (v.rst) begin
            m_cnt  = 0;
            m_ph   = 1'b1;
            m_prev = 1'b0;
        end else begin
            if (v.vs && !m_prev) begin
                if (m_cnt == BF - 1) begin
                    m_cnt = 0;
                    m_ph  = ~m_ph;
                end else begin
                    m_cnt++;
                end
            end
            m_prev = v.vs;
        end
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < NCELL; i++) vram[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
        vram[0]          = 16'h1F41;
        font[16'h41*FH]  = 8'h81;
        vram[2*NC + 3]   = 16'h0F00;
        for (int r = 0; r < FH; r++) font[r] = 8'h00;

        // Reset held 5 cycles with active timing
        for (int i = 0; i < 5; i++) step(mk(1'b1, 8 * i, 0, 1'b1, 1'b1, 1'b1, 1'b0));
        // Cell (0,0) row 0, x = 0..7
        for (int i = 0; i < 8; i++) step(mk(1'b0, i, 0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(mk(1'b0, 479, 0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(mk(1'b0, 0, 16, 1'b1, 1'b1, 1'b0, 1'b0));
        step(mk(1'b0, 500, 5, 1'b1, 1'b1, 1'b0, 1'b0));
        // One-cycle reset in the middle of a line
        for (int i = 0; i < 4; i++) step(mk(1'b0, 16 + i, 40, 1'b1, 1'b1, 1'b0, 1'b0));
        step(mk(1'b1, 20, 40, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++) step(mk(1'b0, 21 + i, 40, 1'b1, 1'b1, 1'b0, 1'b0));

        check("rst_rgb",       32'(obs_log[1]),  32'h0);
        check("rst_vram_addr", 32'(addr_log[1]), 32'h0);
        check("rst_font_addr", 32'(faddr_log[1]), 32'h0);
        check("rst_tail",      32'(obs_log[7]),  32'h0);
        check("first_px_x0",   32'(obs_log[8]),  32'h1FFFF);
        for (int x = 1; x < 7; x++)
            check($sformatf("glyph_bg_x%0d", x), 32'(obs_log[8 + x]), 32'h10015);
        check("glyph_x7",      32'(obs_log[15]), 32'h1FFFF);
        check("addr_eol",      32'(addr_log[14]), 32'd59);
        check("addr_row1",     32'(addr_log[15]), 32'd60);
        check("addr_oob_col",  32'(addr_log[16]), 32'd62);
        check("oob_rgb_den",   32'(obs_log[18]), 32'h10000);
        for (int k = 21; k < 24; k++)
            check($sformatf("midrst_zero@%0d", k), 32'(obs_log[k]), 32'h0);
        check("midrst_den_resume", 32'(obs_log[24][16]), 32'h1);

        // Randomized pixels, timing flags, cursor positions and occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cur_col = 7'($urandom_range(0, 127));
                cur_row = 6'($urandom_range(0, 63));
            end else begin
                cur_col = 7'($urandom_range(0, 9));
                cur_row = 6'($urandom_range(0, 3));
            end
            rv = mk($urandom_range(0, 199) == 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 79),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 63),
                    $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                    1'($urandom), 1'b0);
            step(rv);
        end

`ifdef TEXT_CURSOR_EN
        // Cursor blink across frames 0..4
        cur_col = 7'd3;
        cur_row = 6'd2;
        step(mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) step(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int f = 0; f < 5; f++) begin
            for (int gr = 12; gr < FH; gr++) begin
                for (int xi = 0; xi < FW; xi++) begin
                    if (xi == 0 && gr == 15) cpos15[f] = cyc;
                    if (xi == 0 && gr == 13) cpos13[f] = cyc;
                    step(mk(1'b0, 24 + xi, 32 + gr, 1'b1, 1'b1, 1'b0, 1'b0));
                end
            end
            for (int i = 0; i < 4; i++) step(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < 3; i++) step(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
            for (int i = 0; i < 3; i++) step(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        for (int f = 0; f < 5; f++) begin
            check($sformatf("cursor_row15_f%0d", f), 32'(obs_log[cpos15[f] + 3]),
                  (f == 2 || f == 3) ? 32'h10000 : 32'h1FFFF);
            check($sformatf("cursor_row13_f%0d", f), 32'(obs_log[cpos13[f] + 3]), 32'h10000);
        end
`endif

        for (int i = 0; i < 4; i++) step(mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/text_attr_renderer.md
TEXT_ATTR_RENDERER -- requirements
Module: text_attr_renderer

Interface
REQ-001 Parameter FONT_W, default 8: glyph width in pixels; power of two, 4..16.
REQ-002 Parameter FONT_H, default 16: glyph height in scanlines; power of two, 8..32.
REQ-003 Parameter COLS, default 64: text columns; any value 1..128.
REQ-004 Parameter ROWS, default 32: text rows; any value 1..64.
REQ-005 Parameter BLINK_FRAMES, default 30: frames per cursor blink half-period; 1..255.
REQ-006 i_clk  in  1  pixel clock. The block has one clock; reset is synchronous and active-high.
REQ-007 i_rst  in  1  synchronous, active-high reset.
REQ-008 i_x / i_y  in  10 / 10  current pixel position from timing generators.
REQ-009 i_hde, i_vde, i_hsync, i_vsync  in  1 each  active-area flags and sync pulses, on time.
REQ-010 o_vram_addr  out  clog2(COLS*ROWS)  character buffer read address; synchronous RAM, 1-cycle latency.
REQ-011 i_vram_data  in  16  {attr[7:0], char[7:0]}; attr[3:0] = fg index, attr[7:4] = bg index.
REQ-012 o_font_addr  out  8+clog2(FONT_H)  {char, glyph_row}; synchronous ROM, 1-cycle latency.
REQ-013 i_font_row  in  FONT_W  glyph row bits; MSB is the leftmost pixel.
REQ-014 i_cursor_col / i_cursor_row  in  7 / 6  cursor cell position.
REQ-015 o_hsync, o_vsync, o_den  out  1 each  syncs and (hde & vde), aligned with pixel data.
REQ-016 o_r / o_g / o_b  out  5 / 6 / 5  RGB565 pixel.

Function
REQ-017 Stage 0: register col = i_x >> log2(FONT_W), row = i_y >> log2(FONT_H), o_vram_addr = row*COLS + col, glyph_row, pixel_col, cell_valid = (col < COLS) & (row < ROWS).
REQ-018 Stage 1: register o_font_addr = {i_vram_data[7:0], glyph_row}; attribute and control signals advance one stage.
REQ-019 Stage 2: pixel = i_font_row[FONT_W-1-pixel_col]; color = palette[pixel ? fg : bg]; output registers loaded.
REQ-020 Latency from i_x/i_y/sync inputs to o_r/o_g/o_b/o_hsync/o_vsync/o_den is exactly 3 i_clk cycles, and all outputs are mutually aligned.
REQ-021 Output is RGB 0 whenever the delayed den is 0 or cell_valid is 0; o_vram_addr is not bounded for invalid cells, and read data is discarded.
REQ-022 The palette is a fixed 16-entry RGB565 table: entry 0 black, entry 15 white.
REQ-023 A rising edge of i_vsync, detected in i_clk, increments the frame counter; at BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
REQ-024 Cursor: on the cell matching i_cursor_col/row, for glyph rows FONT_H-2 and FONT_H-1, while blink_phase=1, pixel is forced to 1 (fg colour).
REQ-025 A cursor position outside COLS/ROWS draws no cursor; cursor inputs are sampled in stage 0.

Reset
REQ-026 While i_rst is high, all output and pipeline registers clear to 0: o_r/o_g/o_b = 0, syncs and den = 0, addresses = 0.
REQ-027 On reset, the frame counter is 0 and blink_phase is 1.
REQ-028 Reset mid-frame causes no glitch beyond zeroed outputs; valid output resumes 3 cycles after i_rst falls.

Configuration
REQ-029 Macro TEXT_CURSOR_EN: when defined, the cursor, frame counter and blink logic (REQ-023..025) are built.
REQ-030 When TEXT_CURSOR_EN is undefined, the cursor ports remain but are ignored, no blink logic is synthesised, and pixel output is the glyph only.

Structure
REQ-031 Package text_pkg holds the RGB565 type, the 16-entry palette constant, and the attribute field positions.
REQ-032 Sub-module text_blink_ctrl contains the vsync edge detector, frame counter and blink_phase.
REQ-033 Parameter legality (power-of-two font sizes, ranges) is checked at elaboration, with an error on violation.

Verification
REQ-034 Reset: hold i_rst 5 cycles with active timing -> all outputs 0; after release, first valid pixel appears at cycle 3.
REQ-035 Cell (0,0) = 0x1F41, font row 0x81 -> pixels x=0 and x=7 white, x=1..6 palette[1]; o_den high 3 cycles after i_hde.
REQ-036 COLS=80, FONT_W=8, x=639, y=0 -> o_vram_addr=79; x=0, y=16 -> o_vram_addr=80.
REQ-037 COLS=60, x=500 (col 62) -> RGB 0 while o_den=1.
REQ-038 TEXT_CURSOR_EN, BLINK_FRAMES=2, cursor at (3,2) -> underline on glyph rows 14-15 for frames 0-1, absent for frames 2-3, present again at frame 4.
REQ-039 Assert i_rst mid-line for 1 cycle -> 3 zero output cycles, then aligned output with blink_phase=1.
